// File: rtl/sample_pos_sequencer.sv
// rtl/sample_pos_sequencer.sv - per-sample harmonic phase-position scan engine
// Clears the position RAM after reset, then per trigger reads/advances each harmonic's phase.
module sample_pos_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int POS_WIDTH  = 16,
    parameter int SINE_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_trigger,
    input  logic [POS_WIDTH-1:0]  freq_inc,
    input  logic [ADDR_WIDTH:0]   harmonic_count,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [POS_WIDTH-1:0]  ram_din,
    output logic                  ram_we,
    input  logic [POS_WIDTH-1:0]  ram_dout,
    output logic [SINE_BITS-1:0]  sine_addr,
    output logic [ADDR_WIDTH-1:0] harmonic,
    output logic                  sine_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int ACC_W = POS_WIDTH + ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [ACC_W-1:0] NYQUIST = ACC_W'(1) << (POS_WIDTH - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [CNT_W-1:0]      h;
    logic [CNT_W-1:0]      count_q;
    logic [POS_WIDTH-1:0]  freq_q;
    logic [ACC_W-1:0]      inc_acc;
    logic [POS_WIDTH-1:0]  pos_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_CLEAR;
            clr_addr   <= '0;
            h          <= '0;
            count_q    <= '0;
            freq_q     <= '0;
            inc_acc    <= '0;
            pos_reg    <= '0;
            sine_addr  <= '0;
            harmonic   <= '0;
            sine_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            sine_valid <= 1'b0;
            overrun    <= sample_trigger && (state != S_IDLE);
            case (state)
                S_CLEAR: clr_addr <= clr_addr + 1'b1;
                S_IDLE: begin
                    if (sample_trigger) begin
                        freq_q  <= freq_inc;
                        count_q <= harmonic_count;
                        h       <= '0;
                        inc_acc <= {{ADDR_WIDTH{1'b0}}, freq_inc};
                    end
                end
                S_READ: begin
                    pos_reg    <= ram_dout;
                    sine_addr  <= ram_dout[POS_WIDTH-1 -: SINE_BITS];
                    harmonic   <= h[ADDR_WIDTH-1:0];
                    sine_valid <= 1'b1;
                end
                S_WRITE: begin
                    h       <= h + 1'b1;
                    inc_acc <= inc_acc + {{ADDR_WIDTH{1'b0}}, freq_q};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_CLEAR: if (clr_addr == '1) state_next = S_IDLE;
            S_IDLE:  if (sample_trigger) state_next = S_CHECK;
            S_CHECK: begin
                if (h >= count_q || inc_acc >= NYQUIST) state_next = S_DONE;
                else                                    state_next = S_READ;
            end
            S_READ:  state_next = S_WRITE;
            S_WRITE: state_next = S_CHECK;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_CLEAR;
        endcase
    end

    // Gated by reset so the cycle in which reset is applied never writes the RAM.
    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;
        done     = 1'b0;
        if (!reset) begin
            case (state)
                S_CLEAR: begin
                    ram_addr = clr_addr;
                    ram_we   = 1'b1;
                end
                S_READ: ram_addr = h[ADDR_WIDTH-1:0];
                S_WRITE: begin
                    ram_addr = h[ADDR_WIDTH-1:0];
                    ram_we   = 1'b1;
                    ram_din  = pos_reg + inc_acc[POS_WIDTH-1:0];
                end
                S_DONE: done = 1'b1;
                default: ;
            endcase
        end
    end

    assign busy = reset || (state != S_IDLE);

endmodule
